// File: rtl/pad_frontend_pkg.sv
// Shared types and constants for the pad GPIO front end.
package pad_frontend_pkg;

    // Per-pad electrical configuration driven onto the pad cell.
    typedef struct packed {
        logic [1:0] drv;
        logic       puen;
        logic       slw;
        logic       smt;
    } pad_cfg_t;

    // Output-direction state of one pad.
    typedef enum logic [1:0] {
        S_IN,
        S_TURN,
        S_OUT
    } pad_dir_state_e;

    localparam pad_cfg_t PAD_CFG_RST = '{drv: 2'b00, puen: 1'b0, slw: 1'b0, smt: 1'b0};

endpackage

// File: rtl/pad_in_filter.sv
// Single-pad input conditioning: 2-flop synchroniser, debounce, edge detect.
module pad_in_filter
    import pad_frontend_pkg::*;
#(
    parameter int unsigned DEB_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pad_in_i,
    input  logic [DEB_CNT_W-1:0] deb_thresh_i,
    output logic                 in_o,
    output logic                 rise_o,
    output logic                 fall_o
);

    logic                 sync1_q, sync2_q;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: count while the synced value disagrees with the filtered level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == deb_thresh_i) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Synchroniser, filter state and registered edge pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pad_in_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign in_o   = level_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/pad_gpio_frontend.sv
// Core-side pad front end: output register with hi-Z turnaround, pad config
// registers, and filtered input levels with edge pulses.
module pad_gpio_frontend
    import pad_frontend_pkg::*;
#(
    parameter int unsigned NUM_PADS    = 8,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned DEB_CNT_W   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_PADS-1:0]   out_i,
    input  logic [NUM_PADS-1:0]   oe_i,
    input  logic [NUM_PADS-1:0]   cfg_we_i,
    input  pad_cfg_t              cfg_i,
    input  logic [DEB_CNT_W-1:0]  deb_thresh_i,
    output logic [NUM_PADS-1:0]   pad_out_o,
    output logic [NUM_PADS-1:0]   pad_oen_o,
    output logic [2*NUM_PADS-1:0] pad_drv_o,
    output logic [NUM_PADS-1:0]   pad_puen_o,
    output logic [NUM_PADS-1:0]   pad_slw_o,
    output logic [NUM_PADS-1:0]   pad_smt_o,
    input  logic [NUM_PADS-1:0]   pad_in_i,
    output logic [NUM_PADS-1:0]   in_o,
    output logic [NUM_PADS-1:0]   rise_o,
    output logic [NUM_PADS-1:0]   fall_o,
    output logic [NUM_PADS-1:0]   busy_o
);

    localparam int unsigned TurnW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    // Last turnaround count; unused when TURN_CYCLES is 0 since S_TURN is unreachable.
    localparam logic [TurnW-1:0] TurnLast = TurnW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    logic [NUM_PADS-1:0] out_q;

    // Output data is a plain 1-cycle register, independent of direction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q <= '0;
        end else begin
            out_q <= out_i;
        end
    end

    assign pad_out_o = out_q;

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        pad_dir_state_e   state_q, state_d;
        logic [TurnW-1:0] tcnt_q, tcnt_d;
        logic             oen_q;
        pad_cfg_t         cfg_q;

        // Direction FSM: hi-Z turnaround before driving, immediate release.
        always_comb begin
            state_d = state_q;
            tcnt_d  = tcnt_q;
            case (state_q)
                S_IN: begin
                    if (oe_i[i]) begin
                        tcnt_d  = '0;
                        state_d = (TURN_CYCLES == 0) ? S_OUT : S_TURN;
                    end
                end
                S_TURN: begin
                    if (!oe_i[i]) begin
                        state_d = S_IN;
                    end else if (tcnt_q == TurnLast) begin
                        state_d = S_OUT;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (!oe_i[i]) begin
                        state_d = S_IN;
                    end
                end
                default: state_d = S_IN;
            endcase
        end

        // State register; OEN is registered from the next state.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= S_IN;
                tcnt_q  <= '0;
                oen_q   <= 1'b1;
            end else begin
                state_q <= state_d;
                tcnt_q  <= tcnt_d;
                oen_q   <= (state_d != S_OUT);
            end
        end

        // Config register, writable in any direction state.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cfg_q <= PAD_CFG_RST;
            end else if (cfg_we_i[i]) begin
                cfg_q <= cfg_i;
            end
        end

        assign pad_oen_o[i]        = oen_q;
        assign busy_o[i]           = (state_q == S_TURN);
        assign pad_drv_o[2*i +: 2] = cfg_q.drv;
        assign pad_puen_o[i]       = cfg_q.puen;
        assign pad_slw_o[i]        = cfg_q.slw;
        assign pad_smt_o[i]        = cfg_q.smt;

        pad_in_filter #(
            .DEB_CNT_W(DEB_CNT_W)
        ) u_in_filter (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .pad_in_i    (pad_in_i[i]),
            .deb_thresh_i(deb_thresh_i),
            .in_o        (in_o[i]),
            .rise_o      (rise_o[i]),
            .fall_o      (fall_o[i])
        );
    end

endmodule

// File: tb/tb_pad_gpio_frontend.sv
// Randomised and directed bench for pad_gpio_frontend with a behavioural model.
module tb_pad_gpio_frontend;
    import pad_frontend_pkg::*;

    localparam int NP   = 8;
    localparam int TURN = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [NP-1:0] out_i, oe_i, cfg_we_i, pad_in_i;
    pad_cfg_t      cfg_i;
    logic [7:0]    deb_thresh_i;
    logic [NP-1:0] pad_out_o, pad_oen_o, pad_puen_o, pad_slw_o, pad_smt_o;
    logic [NP-1:0] in_o, rise_o, fall_o, busy_o;
    logic [2*NP-1:0] pad_drv_o;

    always #5 clk = ~clk;

    pad_gpio_frontend #(
        .NUM_PADS   (NP),
        .TURN_CYCLES(TURN),
        .DEB_CNT_W  (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .out_i       (out_i),
        .oe_i        (oe_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_i       (cfg_i),
        .deb_thresh_i(deb_thresh_i),
        .pad_out_o   (pad_out_o),
        .pad_oen_o   (pad_oen_o),
        .pad_drv_o   (pad_drv_o),
        .pad_puen_o  (pad_puen_o),
        .pad_slw_o   (pad_slw_o),
        .pad_smt_o   (pad_smt_o),
        .pad_in_i    (pad_in_i),
        .in_o        (in_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .busy_o      (busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: oe run length, delayed input samples, accepted levels.
    int            hi_cnt [NP];
    int            run    [NP];
    pad_cfg_t      m_cfg  [NP];
    logic [NP-1:0] m_out, m_s1, m_s2, m_in, m_rise, m_fall;

    task automatic model_edge();
        if (rst_i) begin
            m_out = '0; m_s1 = '0; m_s2 = '0; m_in = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < NP; i++) begin
                hi_cnt[i] = 0;
                run[i]    = 0;
                m_cfg[i]  = PAD_CFG_RST;
            end
        end else begin
            m_out  = out_i;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < NP; i++) begin
                if (oe_i[i]) begin
                    if (hi_cnt[i] < 1000) hi_cnt[i]++;
                end else begin
                    hi_cnt[i] = 0;
                end
                if (cfg_we_i[i]) m_cfg[i] = cfg_i;
                // A new level is accepted once it has persisted thresh+1 edges.
                if (m_s2[i] != m_in[i]) begin
                    run[i]++;
                    if (run[i] == int'(deb_thresh_i) + 1) begin
                        m_in[i]   = m_s2[i];
                        m_rise[i] = m_s2[i];
                        m_fall[i] = ~m_s2[i];
                        run[i]    = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = pad_in_i;
        end
    endtask

    task automatic compare_all();
        logic [NP-1:0]   e_oen, e_busy, e_puen, e_slw, e_smt;
        logic [2*NP-1:0] e_drv;
        for (int i = 0; i < NP; i++) begin
            e_oen[i]          = !(hi_cnt[i] >= TURN + 1);
            e_busy[i]         = (hi_cnt[i] >= 1) && (hi_cnt[i] <= TURN);
            e_drv[2*i +: 2]   = m_cfg[i].drv;
            e_puen[i]         = m_cfg[i].puen;
            e_slw[i]          = m_cfg[i].slw;
            e_smt[i]          = m_cfg[i].smt;
        end
        check("oen", pad_oen_o, e_oen);
        check("busy", busy_o, e_busy);
        check("out", pad_out_o, m_out);
        check("drv", pad_drv_o, e_drv);
        check("puen", pad_puen_o, e_puen);
        check("slw", pad_slw_o, e_slw);
        check("smt", pad_smt_o, e_smt);
        check("in", in_o, m_in);
        check("rise", rise_o, m_rise);
        check("fall", fall_o, m_fall);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    int rises;

    initial begin
        rst_i = 1'b1; out_i = '0; oe_i = '0; cfg_we_i = '0; pad_in_i = '0;
        cfg_i = PAD_CFG_RST; deb_thresh_i = 8'd3;
        step(); step();
        rst_i = 1'b0;

        // Quiet idle after reset.
        check("rst_oen", pad_oen_o, 8'hFF);
        check("rst_out", pad_out_o, 8'h00);
        check("rst_in", in_o, 8'h00);
        for (int k = 0; k < 10; k++) begin
            step();
            check("idle_pulse", rise_o | fall_o, 8'h00);
        end

        // Turnaround on pad 0.
        oe_i[0] = 1'b1;
        step(); check("turn_oen1", pad_oen_o[0], 1); check("turn_busy1", busy_o[0], 1);
        step(); check("turn_oen2", pad_oen_o[0], 1); check("turn_busy2", busy_o[0], 1);
        step(); check("turn_oen3", pad_oen_o[0], 0); check("turn_busy3", busy_o[0], 0);
        step(); check("drive_hold", pad_oen_o[0], 0);
        oe_i[0] = 1'b0;
        step(); check("release_oen", pad_oen_o[0], 1);

        // One-cycle oe pulse on pad 3 aborts.
        oe_i[3] = 1'b1;
        step();
        oe_i[3] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("abort_oen", pad_oen_o[3], 1);
        end

        // Glitch rejection then accepted edge on pad 5 with threshold 3.
        pad_in_i[5] = 1'b1;
        step(); step(); step();
        pad_in_i[5] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("glitch_in", in_o[5], 0);
            check("glitch_rise", rise_o[5], 0);
        end
        pad_in_i[5] = 1'b1;
        rises = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (rise_o[5]) rises++;
            check("deb_lat", in_o[5], (k >= 6) ? 1 : 0);
        end
        check("deb_rises", rises, 1);

        // Config write to pad 2 only.
        cfg_we_i = 8'h04;
        cfg_i    = '{drv: 2'b11, puen: 1'b1, slw: 1'b0, smt: 1'b1};
        step();
        cfg_we_i = '0;
        check("cfg_drv", pad_drv_o, 16'h0030);
        check("cfg_puen", pad_puen_o, 8'h04);
        check("cfg_smt", pad_smt_o, 8'h04);
        check("cfg_slw", pad_slw_o, 8'h00);

        // Reset while pad 1 is in turnaround.
        oe_i[1] = 1'b1;
        step();
        check("pre_rst_busy", busy_o[1], 1);
        rst_i = 1'b1;
        step();
        check("rst_turn_oen", pad_oen_o[1], 1);
        check("rst_turn_busy", busy_o[1], 0);
        check("rst_cfg_drv", pad_drv_o, 16'h0000);
        check("rst_no_fall", fall_o[5], 0);
        oe_i = '0; pad_in_i = '0;
        rst_i = 1'b0;
        step();

        // Randomised phases; threshold changes only under reset.
        for (int ph = 0; ph < 4; ph++) begin
            rst_i = 1'b1;
            deb_thresh_i = (ph == 3) ? 8'd5 : 8'(ph);
            step();
            rst_i = 1'b0;
            for (int k = 0; k < 500; k++) begin
                out_i = NP'($urandom);
                for (int i = 0; i < NP; i++) begin
                    if ($urandom_range(0, 3) == 0) oe_i[i] = ~oe_i[i];
                    if ($urandom_range(0, 5) == 0) pad_in_i[i] = ~pad_in_i[i];
                end
                cfg_we_i = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0;
                cfg_i    = pad_cfg_t'($urandom);
                if ($urandom_range(0, 199) == 0) rst_i = 1'b1;
                step();
                rst_i = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/pad_gpio_frontend.md
Name: pad_gpio_frontend

Overview:
- Per-pad core-side front end that sits directly upstream of the behavioural/physical IO pad cells.
- Drives each pad's I/OEN/PUEN/DRV/SLW/SMT pins and consumes its O pin.
- Output path: registers core data and enforces a hi-Z turnaround before enabling a driver, avoiding bus contention.
- Input path: synchronises, debounces and edge-detects O, then hands clean levels and edge pulses to GPIO/interrupt logic.

Parameters:
- NUM_PADS, 8, number of pads handled (vector width of all per-pad ports).
- TURN_CYCLES, 2, hi-Z cycles inserted before OEN goes low (0 = no turnaround).
- DEB_CNT_W, 8, width of debounce threshold/counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- out_i  in  NUM_PADS  core output data.
- oe_i  in  NUM_PADS  core output-enable request (1 = drive).
- cfg_we_i  in  NUM_PADS  per-pad config write strobe.
- cfg_i  in  pad_cfg_t  config value {drv[1:0], puen, slw, smt}, applied to every pad whose cfg_we_i bit is set.
- deb_thresh_i  in  DEB_CNT_W  debounce threshold, shared by all pads.
- pad_out_o  out  NUM_PADS  to pad I.
- pad_oen_o  out  NUM_PADS  to pad OEN (1 = hi-Z).
- pad_drv_o  out  2*NUM_PADS  to pad DRV.
- pad_puen_o, pad_slw_o, pad_smt_o  out  NUM_PADS each  to pad PUEN/SLW/SMT.
- pad_in_i  in  NUM_PADS  from pad O (asynchronous).
- in_o  out  NUM_PADS  filtered input level.
- rise_o, fall_o  out  NUM_PADS each  one-cycle edge pulses.
- busy_o  out  NUM_PADS  pad is in turnaround.

Behaviour:
- Reset values: pad_oen_o all 1; pad_out_o 0; drv 2'b00; puen/slw/smt 0; in_o 0; rise_o/fall_o 0; busy_o 0; all FSMs in S_IN; sync flops and counters 0.
- Output data: pad_out_o <= out_i every cycle, 1-cycle latency, independent of the FSM.
- Per-pad FSM:
  - S_IN: oen=1. On oe_i=1: go to S_TURN with counter=0, or straight to S_OUT if TURN_CYCLES=0.
  - S_TURN: oen=1, busy=1, counter increments each cycle. Counter==TURN_CYCLES-1 with oe_i=1 -> S_OUT. oe_i=0 at any point -> S_IN immediately (abort).
  - S_OUT: oen=0. On oe_i=0 -> S_IN; oen=1 on the next edge (release has no turnaround).
  - pad_oen_o is registered from the next state. Latency oe_i 0->1 to OEN low: 1+TURN_CYCLES cycles. Latency oe_i 1->0 to OEN high: 1 cycle.
- Config: a pad's cfg register loads cfg_i at the edge where its cfg_we_i bit is 1; 1-cycle latency. Writes are accepted in any FSM state.
- Input path, per pad:
  - 2-flop synchroniser on pad_in_i.
  - Debounce: counter resets whenever the synced value equals in_o.
  - While synced != in_o, the counter increments; when counter==deb_thresh_i, in_o toggles and the counter clears.
  - A change must therefore hold deb_thresh_i+1 cycles. deb_thresh_i=0: 1 cycle.
  - A glitch shorter than that leaves in_o unchanged.
  - Counter saturates at its maximum and never wraps.
  - Total pad-to-in_o latency: 2+deb_thresh_i+1 cycles.
  - rise_o/fall_o pulse in the same cycle in_o updates; never both set.
  - A deb_thresh_i change mid-count uses the new value from the next comparison.
- The input path runs while the pad is driven (loopback of driven value).
- Reset asserted mid-turnaround: FSM to S_IN, OEN high on the next edge. No edge pulses are generated by reset or its release.

Decomposition:
- Package pad_frontend_pkg: pad_cfg_t packed struct {logic [1:0] drv; logic puen; logic slw; logic smt;}, FSM enum pad_dir_state_e {S_IN, S_TURN, S_OUT}, and the reset config constant PAD_CFG_RST.
- Sub-module pad_in_filter (single pad: sync + debounce + edge detect), instantiated NUM_PADS times.
- Direction FSM and config regs stay in the top level, in a generate loop.

Test Plan:
- Reset then release -> pad_oen_o=8'hFF, pad_out_o=0, in_o=0, no rise/fall pulse for 10 cycles with pad_in_i=0.
- TURN_CYCLES=2, oe_i[0] 0->1 at cycle t:
  - pad_oen_o[0] high through t+2, low at t+3; busy_o[0] high for 2 cycles.
  - oe_i[0]->0 at u: pad_oen_o[0] high at u+1.
- oe_i[3] pulsed high 1 cycle (TURN_CYCLES=2) -> FSM aborts to S_IN; pad_oen_o[3] never goes low.
- deb_thresh_i=3:
  - pad_in_i[5] high for 3 cycles then low -> in_o[5] stays 0, no pulses.
  - pad_in_i[5] high for 10 cycles -> in_o[5] rises exactly 6 cycles after the input edge, with a single rise_o[5] pulse.
- cfg_we_i=8'h04, cfg_i={drv=2'b11, puen=1, slw=0, smt=1} -> next cycle only pad 2 shows drv=11, puen=1, smt=1; other pads unchanged.
- rst_i asserted while pad 1 is in S_TURN -> next edge: pad_oen_o[1]=1, busy_o[1]=0, cfg back to PAD_CFG_RST.
